// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and operand-classification helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic a_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Upper register select: high product half, or remainder for divides.
    function automatic logic hi_sel(input logic [2:0] f3);
        return f3[2] ? f3[1] : (f3[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit's datapath: shift-add multiply or restoring
// trial-subtract divide, selected by div. Ports: div, acc/q/m in, acc_n/q_n out.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] m,
    output logic [XLEN-1:0] acc_n,
    output logic [XLEN-1:0] q_n
);

    logic [XLEN:0] sum;
    logic [XLEN:0] sh;
    logic [XLEN:0] diff;

    always_comb begin
        sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        sh    = {acc, q[XLEN-1]};
        diff  = sh - {1'b0, m};
        acc_n = sum[XLEN:1];
        q_n   = {sum[0], q[XLEN-1:1]};
        if (div) begin
            // Remainder stays below m, so the restored value fits XLEN bits.
            if (!diff[XLEN]) begin
                acc_n = diff[XLEN-1:0];
                q_n   = {q[XLEN-2:0], 1'b1};
            end else begin
                acc_n = sh[XLEN-1:0];
                q_n   = {q[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M mul/div, one bit per clock, valid/ready on both sides.
// Ports: clk, rstn, in_valid/in_ready, a, b, funct3, out_valid/out_ready, c.
// Option MULDIV_EARLY_OUT_EN: trivial operand cases skip CALC (IDLE -> FIX).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] c
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic [2:0]        f3_r;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   m;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   acc_n;
    logic [XLEN-1:0]   q_n;
    logic [XLEN-1:0]   c_r;
    logic [XLEN-1:0]   res;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic              ovf;
    logic              accept;
    logic              early;
    logic              last;
    logic              sa_in;
    logic              sb_in;

    assign accept = in_valid && (state == IDLE);
    assign last   = (cnt == CW'(XLEN - 1));
    assign sa_in  = a_signed(funct3) && a[XLEN-1];
    assign sb_in  = b_signed(funct3) && b[XLEN-1];
    assign a_mag  = sa_in ? -a : a;
    assign b_mag  = sb_in ? -b : b;
    assign c      = c_r;

`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        if (is_div(funct3))
            early = (b == '0) ||
                    (a_signed(funct3) && (a == SMIN) && (b == '1));
        else
            early = (a == '0) || (b == '0);
    end
`else
    assign early = 1'b0;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div   (f3_r[2]),
        .acc   (acc),
        .q     (q),
        .m     (m),
        .acc_n (acc_n),
        .q_n   (q_n)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept)    state_n = early ? FIX : CALC;
            CALC: if (last)      state_n = FIX;
            FIX:                 state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default:             state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Sign correction and RV32M special cases; the overrides also cover
    // the early-out path where acc/q never iterated.
    always_comb begin
        prod   = {acc, q};
        prod_s = (sa ^ sb) ? -prod : prod;
        quo    = (sa ^ sb) ? -q : q;
        rem    = sa ? -acc : acc;
        ovf    = is_div(f3_r) && a_signed(f3_r) &&
                 (a_r == SMIN) && (b_r == '1);
        if (is_div(f3_r)) begin
            if (b_r == '0)
                res = f3_r[1] ? a_r : '1;
            else if (ovf)
                res = f3_r[1] ? '0 : SMIN;
            else
                res = hi_sel(f3_r) ? rem : quo;
        end else begin
            if ((a_r == '0) || (b_r == '0))
                res = '0;
            else
                res = hi_sel(f3_r) ? prod_s[2*XLEN-1:XLEN]
                                   : prod_s[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            a_r  <= '0;
            b_r  <= '0;
            f3_r <= '0;
            sa   <= 1'b0;
            sb   <= 1'b0;
            m    <= '0;
            acc  <= '0;
            q    <= '0;
            c_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r  <= a;
                        b_r  <= b;
                        f3_r <= funct3;
                        sa   <= sa_in;
                        sb   <= sb_in;
                        acc  <= '0;
                        cnt  <= '0;
                        // Divide iterates the dividend in q; multiply
                        // shifts the multiplier out of q.
                        if (is_div(funct3)) begin
                            q <= a_mag;
                            m <= b_mag;
                        end else begin
                            q <= b_mag;
                            m <= a_mag;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_n;
                    q   <= q_n;
                    cnt <= last ? '0 : cnt + CW'(1);
                end
                FIX:     c_r <= res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
// Hand-computed RV32M vectors, latency, back-pressure and reset abort.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  funct3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] c;

    int tests = 0;
    int fails = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LSP = 1;
`else
    localparam int LSP = 33;
`endif
    localparam int LFULL = 33;

    muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] f,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        funct3   = f;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_c"}, c, exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ovlo"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_rdy", 32'(in_ready), 32'd1);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_c", c, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        do_op("mul_neg", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LFULL);
        do_op("mulhu_ff", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LFULL);
        do_op("mulh_ff", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LFULL);
        do_op("mulhsu_ff", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LFULL);
        do_op("mul_ff", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, LFULL);
        do_op("mul_zero", 3'd0, 32'd0, 32'd12345, 32'd0, LSP);

        do_op("div_m7", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LFULL);
        do_op("rem_m7", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LFULL);
        do_op("divu_m7", 3'd5, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, LFULL);
        do_op("remu_m7", 3'd7, 32'hFFFFFFF9, 32'd2, 32'h00000001, LFULL);

        do_op("div_z", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, LSP);
        do_op("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, LSP);
        do_op("rem_z", 3'd6, 32'd5, 32'd0, 32'd5, LSP);
        do_op("remu_z", 3'd7, 32'd5, 32'd0, 32'd5, LSP);
        do_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LSP);
        do_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, LSP);

        // Back-pressure: result held while out_ready stays low.
        @(negedge clk);
        in_valid = 1'b1;
        funct3   = 3'd0;
        a        = 32'd7;
        b        = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_ov0", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            funct3   = 3'd5;
            a        = 32'(i + 50);
            b        = 32'd1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp_c", c, 32'd21);
            chk("bp_ov", 32'(out_valid), 32'd1);
            chk("bp_rdy", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_ovlo", 32'(out_valid), 32'd0);
        chk("bp_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_noacc", 32'(in_ready), 32'd1);

        // Reset abort mid-CALC.
        @(negedge clk);
        in_valid = 1'b1;
        funct3   = 3'd5;
        a        = 32'd1000;
        b        = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("ab_ov", 32'(out_valid), 32'd0);
        chk("ab_rdy", 32'(in_ready), 32'd1);
        chk("ab_c", c, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, LFULL);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
